dev_reshuffler_csr_arbiter: RTL and testbench

Round-robin arbiter that shares the reshuffler CSR manager port between NumReq requesters, such as a host core and a DMA/config sequencer.
- Accepts one request at a time from the requester ports.
- Forwards it to the CSR manager's req valid/ready interface.
- Routes the single response back to the requester that issued it.
- Only one transaction is outstanding at any time, so responses never mix.

---
 rtl/dev_reshuffler_csr_arbiter.sv | 149 ++++++++++++++
 tb/tb_dev_reshuffler_csr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_reshuffler_csr_arbiter.sv
// Round-robin arbiter sharing one CSR manager port between NumReq requesters, one transaction in flight.
// Optional per-requester grant counters are built when DEV_RESHUFFLER_CSR_ARB_PERF_EN is defined.
`default_nettype none

module dev_reshuffler_csr_arbiter #(
  parameter int NumReq       = 2,
  parameter int RegCount     = 8,
  parameter int RegDataWidth = 32,
  parameter int RegAddrWidth = $clog2(RegCount)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumReq-1:0][RegAddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0][RegDataWidth-1:0]    req_wr_data_i,
  input  logic [NumReq-1:0]                      req_wr_en_i,
  input  logic [NumReq-1:0]                      req_valid_i,
  output logic [NumReq-1:0]                      req_ready_o,
  output logic [NumReq-1:0][RegDataWidth-1:0]    rsp_data_o,
  output logic [NumReq-1:0]                      rsp_valid_o,
  input  logic [NumReq-1:0]                      rsp_ready_i,
  output logic [RegAddrWidth-1:0]                csr_addr_o,
  output logic [RegDataWidth-1:0]                csr_wr_data_o,
  output logic                                   csr_wr_en_o,
  output logic                                   csr_req_valid_o,
  input  logic                                   csr_req_ready_i,
  input  logic [RegDataWidth-1:0]                csr_rd_data_i,
  input  logic                                   csr_rsp_valid_i,
  output logic                                   csr_rsp_ready_o,
  output logic [NumReq-1:0][31:0]                perf_grant_cnt_o
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  state_e                  state;
  logic [PtrW-1:0]         rr_ptr;
  logic [PtrW-1:0]         owner;
  logic [PtrW-1:0]         winner;
  logic [PtrW-1:0]         next_ptr;
  logic                    found;
  logic                    in_idle;
  logic                    in_req;
  logic                    in_rsp;
  logic                    accept;
  int                      cand;
  logic [RegAddrWidth-1:0] hold_addr;
  logic [RegDataWidth-1:0] hold_wdata;
  logic                    hold_wen;

  // Search starts at rr_ptr and wraps with a true modulo, so non-power-of-2 NumReq works.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 0; k < NumReq; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!found && req_valid_i[cand[PtrW-1:0]]) begin
        found  = 1'b1;
        winner = cand[PtrW-1:0];
      end
    end
  end

  assign next_ptr = (owner == PtrW'(NumReq - 1)) ? '0 : owner + 1'b1;

  // Gating on rst_ni keeps req_ready_o low while reset is held, not just after the first edge.
  assign in_idle = (state == IDLE) && rst_ni;
  assign in_req  = (state == REQ);
  assign in_rsp  = (state == RSP);
  assign accept  = in_idle && found;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_wen   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            hold_addr  <= req_addr_i[winner];
            hold_wdata <= req_wr_data_i[winner];
            hold_wen   <= req_wr_en_i[winner];
            owner      <= winner;
            state      <= REQ;
          end
        end
        REQ: begin
          if (csr_req_ready_i) state <= RSP;
        end
        RSP: begin
          if (csr_rsp_valid_i && rsp_ready_i[owner]) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = accept && (winner == PtrW'(i));
      if (in_rsp && (owner == PtrW'(i))) begin
        rsp_valid_o[i] = csr_rsp_valid_i;
        rsp_data_o[i]  = csr_rd_data_i;
      end
    end
  end

  assign csr_req_valid_o = in_req;
  assign csr_addr_o      = in_req ? hold_addr  : '0;
  assign csr_wr_data_o   = in_req ? hold_wdata : '0;
  assign csr_wr_en_o     = in_req && hold_wen;
  // A response arriving outside RSP is left pending at the manager.
  assign csr_rsp_ready_o = in_rsp && rsp_ready_i[owner];

`ifdef DEV_RESHUFFLER_CSR_ARB_PERF_EN
  logic [NumReq-1:0][31:0] grant_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt <= '0;
    end else if (accept) begin
      grant_cnt[winner] <= grant_cnt[winner] + 32'd1;
    end
  end

  assign perf_grant_cnt_o = grant_cnt;
`else
  assign perf_grant_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dev_reshuffler_csr_arbiter.sv
// Scoreboard bench for dev_reshuffler_csr_arbiter: random and directed traffic against a queue-based model.
`timescale 1ns/1ps
`default_nettype none

module tb_dev_reshuffler_csr_arbiter;
  localparam int NR = 3;
  localparam int RC = 8;
  localparam int DW = 32;
  localparam int AW = 3;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic [NR-1:0][AW-1:0]   req_addr_i = '0;
  logic [NR-1:0][DW-1:0]   req_wr_data_i = '0;
  logic [NR-1:0]           req_wr_en_i = '0;
  logic [NR-1:0]           req_valid_i = '0;
  logic [NR-1:0]           req_ready_o;
  logic [NR-1:0][DW-1:0]   rsp_data_o;
  logic [NR-1:0]           rsp_valid_o;
  logic [NR-1:0]           rsp_ready_i = '0;
  logic [AW-1:0]           csr_addr_o;
  logic [DW-1:0]           csr_wr_data_o;
  logic                    csr_wr_en_o;
  logic                    csr_req_valid_o;
  logic                    csr_req_ready_i = 1'b0;
  logic [DW-1:0]           csr_rd_data_i = '0;
  logic                    csr_rsp_valid_i = 1'b0;
  logic                    csr_rsp_ready_o;
  logic [NR-1:0][31:0]     perf_grant_cnt_o;

  always #5 clk_i = ~clk_i;

  dev_reshuffler_csr_arbiter #(
    .NumReq(NR), .RegCount(RC), .RegDataWidth(DW), .RegAddrWidth(AW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_addr_i(req_addr_i), .req_wr_data_i(req_wr_data_i), .req_wr_en_i(req_wr_en_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .csr_addr_o(csr_addr_o), .csr_wr_data_o(csr_wr_data_o), .csr_wr_en_o(csr_wr_en_o),
    .csr_req_valid_o(csr_req_valid_o), .csr_req_ready_i(csr_req_ready_i),
    .csr_rd_data_i(csr_rd_data_i), .csr_rsp_valid_i(csr_rsp_valid_i),
    .csr_rsp_ready_o(csr_rsp_ready_o), .perf_grant_cnt_o(perf_grant_cnt_o)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] wdata; logic wen; } creq_t;
  typedef struct { int port; logic [DW-1:0] data; } crsp_t;

  creq_t       csr_q[$];
  crsp_t       rsp_q[$];
  creq_t       c_ent;
  crsp_t       r_ent;
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model: arbitration pointer, register file view and grant history.
  bit          busy;
  int          ptr;
  int          owner_m;
  int          w;
  logic [DW-1:0] ref_mem [RC];
  int unsigned perf_exp [NR];
  int          glog[$];
  logic [NR-1:0]         exp_rdy;
  logic [NR-1:0]         exp_rv;
  logic [NR-1:0][DW-1:0] exp_rd;
  bit          in_rsp_m;

  // Handshake flags seen at the falling edge, consumed after the next rising edge.
  logic [NR-1:0] acc;
  bit          mgr_req_hs;
  bit          mgr_rsp_hs;
  logic [DW-1:0] mgr_mem [RC];
  logic [DW-1:0] mgr_data;
  bit          mgr_pend;
  int          mgr_wait;
  int          mgr_req_count = 0;
  bit          rand_en = 1'b0;
  logic [NR-1:0] sticky = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      busy = 1'b0; ptr = 0; owner_m = 0;
      csr_q.delete(); rsp_q.delete(); glog.delete();
      for (int a = 0; a < RC; a++) begin ref_mem[a] = '0; mgr_mem[a] = '0; end
      for (int i = 0; i < NR; i++) perf_exp[i] = 0;
      acc = '0; mgr_req_hs = 1'b0; mgr_rsp_hs = 1'b0;
    end else begin
      // Phase is inferred from the queues: request pending -> REQ, request gone -> RSP.
      in_rsp_m = busy && (csr_q.size() == 0);
      exp_rv = '0; exp_rd = '0;
      if (in_rsp_m) begin
        exp_rv[owner_m] = csr_rsp_valid_i;
        exp_rd[owner_m] = csr_rd_data_i;
      end
      chk("csr_req_valid", csr_req_valid_o, busy && (csr_q.size() != 0));
      chk("csr_rsp_ready", csr_rsp_ready_o, in_rsp_m ? rsp_ready_i[owner_m] : 1'b0);
      chk("rsp_valid", rsp_valid_o, exp_rv);
      chk("rsp_data_vec", rsp_data_o, exp_rd);

      exp_rdy = '0; w = -1;
      if (!busy)
        for (int k = 0; k < NR; k++)
          if (w < 0 && req_valid_i[(ptr + k) % NR]) w = (ptr + k) % NR;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("grant", req_ready_o, exp_rdy);
      acc = req_ready_o & req_valid_i;
      if (w >= 0) begin
        c_ent.addr = req_addr_i[w]; c_ent.wdata = req_wr_data_i[w]; c_ent.wen = req_wr_en_i[w];
        csr_q.push_back(c_ent);
        r_ent.port = w;
        r_ent.data = req_wr_en_i[w] ? req_wr_data_i[w] : ref_mem[req_addr_i[w]];
        if (req_wr_en_i[w]) ref_mem[req_addr_i[w]] = req_wr_data_i[w];
        rsp_q.push_back(r_ent);
        busy = 1'b1; owner_m = w; perf_exp[w]++; glog.push_back(w);
      end

      mgr_req_hs = csr_req_valid_o && csr_req_ready_i;
      if (mgr_req_hs) begin
        if (csr_wr_en_o) begin mgr_mem[csr_addr_o] = csr_wr_data_o; mgr_data = csr_wr_data_o; end
        else mgr_data = mgr_mem[csr_addr_o];
        if (csr_q.size() == 0) chk("csr_req_unexpected", 1, 0);
        else begin
          c_ent = csr_q.pop_front();
          chk("csr_addr", csr_addr_o, c_ent.addr);
          chk("csr_wdata", csr_wr_data_o, c_ent.wdata);
          chk("csr_wen", csr_wr_en_o, c_ent.wen);
        end
      end
      mgr_rsp_hs = csr_rsp_valid_i && csr_rsp_ready_o;

      for (int i = 0; i < NR; i++) begin
        if (rsp_valid_o[i] && rsp_ready_i[i]) begin
          if (rsp_q.size() == 0) chk("rsp_unexpected", i, 99);
          else begin
            r_ent = rsp_q.pop_front();
            chk("rsp_port", i, r_ent.port);
            chk("rsp_data", rsp_data_o[i], r_ent.data);
            busy = 1'b0;
            ptr = (r_ent.port + 1) % NR;
          end
        end
      end
    end
  end

  task automatic new_req(input int i);
    req_addr_i[i]    = AW'($urandom_range(0, RC - 1));
    req_wr_data_i[i] = $urandom;
    req_wr_en_i[i]   = 1'($urandom);
    req_valid_i[i]   = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
    req_addr_i[i] = a; req_wr_data_i[i] = d; req_wr_en_i[i] = we; req_valid_i[i] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
    if (mgr_rsp_hs) begin csr_rsp_valid_i = 1'b0; csr_rd_data_i = $urandom; end
    if (mgr_req_hs) begin
      mgr_req_count++;
      mgr_pend = 1'b1;
      mgr_wait = rand_en ? int'($urandom_range(0, 2)) : 0;
    end
    if (mgr_pend) begin
      if (mgr_wait == 0) begin csr_rsp_valid_i = 1'b1; csr_rd_data_i = mgr_data; mgr_pend = 1'b0; end
      else mgr_wait--;
    end
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        if (sticky[i]) new_req(i); else req_valid_i[i] = 1'b0;
      end else if (rand_en) begin
        if (req_valid_i[i]) begin if ($urandom_range(0, 15) == 0) req_valid_i[i] = 1'b0; end
        else if ($urandom_range(0, 2) == 0) new_req(i);
      end
    end
    if (rand_en) begin
      csr_req_ready_i = ($urandom_range(0, 3) != 0);
      rsp_ready_i     = NR'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; rand_en = 1'b0; sticky = '0; req_valid_i = '0;
    csr_rsp_valid_i = 1'b0; mgr_pend = 1'b0; mgr_wait = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic wait_grants(input int n, input string name);
    int t = 0;
    while ((glog.size() < n || busy) && t < 100) begin step(); t++; end
    chk(name, (t < 100), 1'b1);
  endtask

  task automatic drain_and_perf();
    int t = 0;
    rand_en = 1'b0; sticky = '0; req_valid_i = '0;
    rsp_ready_i = '1; csr_req_ready_i = 1'b1;
    while ((busy || rsp_q.size() != 0) && t < 100) begin step(); t++; end
    chk("drain_rsp_q", rsp_q.size(), 0);
    chk("drain_csr_q", csr_q.size(), 0);
    @(negedge clk_i);
    for (int i = 0; i < NR; i++) begin
`ifdef DEV_RESHUFFLER_CSR_ARB_PERF_EN
      chk("perf_cnt", perf_grant_cnt_o[i], perf_exp[i]);
`else
      chk("perf_cnt_off", perf_grant_cnt_o[i], 0);
`endif
    end
  endtask

  initial begin
    int a_req;
    int order [4] = '{0, 1, 0, 1};

    // Reset state, with every input pushing for activity.
    req_valid_i = '1; rsp_ready_i = '1; csr_req_ready_i = 1'b1; csr_rsp_valid_i = 1'b1;
    #3;
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_csr_req_valid", csr_req_valid_o, 0);
    chk("rst_csr_addr", {csr_addr_o, csr_wr_data_o, csr_wr_en_o}, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_csr_rsp_ready", csr_rsp_ready_o, 0);
    chk("rst_perf", perf_grant_cnt_o, 0);
    do_reset();

    // Write then read back through requester 0, with latency checks.
    rsp_ready_i = '1; csr_req_ready_i = 1'b1;
    set_req(0, 3'd3, 32'hDEADBEEF, 1'b1);
    step();
    @(negedge clk_i);
    chk("lat_csr_req", {csr_req_valid_o, csr_wr_en_o, csr_addr_o, csr_wr_data_o}, {1'b1, 1'b1, 3'd3, 32'hDEADBEEF});
    step();
    @(negedge clk_i);
    chk("lat_rsp_valid", rsp_valid_o, 3'b001);
    step();
    set_req(0, 3'd3, 32'h0, 1'b0);
    wait_grants(2, "rdback_timeout");
    drain_and_perf();

    // Contention between requesters 0 and 1 from a fresh pointer.
    do_reset();
    rsp_ready_i = '1; csr_req_ready_i = 1'b1;
    sticky = 3'b011; new_req(0); new_req(1);
    wait_grants(4, "contention_timeout");
    for (int k = 0; k < 4; k++) chk("contention_order", (glog.size() > k) ? glog[k] : 99, order[k]);
    drain_and_perf();

    // Request and response backpressure on requester 1.
    a_req = mgr_req_count;
    rsp_ready_i = '0; csr_req_ready_i = 1'b0;
    set_req(1, 3'd5, 32'hA5A5_0F0F, 1'b1);
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("bp_req_hold", {csr_req_valid_o, csr_addr_o, csr_wr_data_o}, {1'b1, 3'd5, 32'hA5A5_0F0F});
      step();
    end
    csr_req_ready_i = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("bp_rsp_hold", {rsp_valid_o[1], csr_rsp_ready_o}, 2'b10);
      step();
    end
    drain_and_perf();
    chk("bp_single_issue", mgr_req_count - a_req, 1);

    // Pointer wrap: serve req2, then req0 must beat req2.
    do_reset();
    rsp_ready_i = '1; csr_req_ready_i = 1'b1;
    new_req(2);
    wait_grants(1, "wrap_first_timeout");
    new_req(0); new_req(2);
    wait_grants(2, "wrap_second_timeout");
    chk("wrap_grant", (glog.size() > 1) ? glog[1] : 99, 0);
    drain_and_perf();

    // Reset while a request waits for the manager.
    rsp_ready_i = '1; csr_req_ready_i = 1'b0;
    set_req(1, 3'd6, 32'h1234_5678, 1'b1);
    step();
    #2;
    chk("pre_rst_req_valid", csr_req_valid_o, 1'b1);
    rst_ni = 1'b0; req_valid_i = '1;
    #1;
    chk("midrst_csr", {csr_req_valid_o, csr_addr_o, csr_wr_data_o, csr_wr_en_o}, 0);
    chk("midrst_req_ready", req_ready_o, 0);
    req_valid_i = '0; csr_req_ready_i = 1'b1; csr_rsp_valid_i = 1'b0; mgr_pend = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    new_req(1); new_req(2);
    wait_grants(1, "postrst_timeout");
    chk("postrst_grant", (glog.size() > 0) ? glog[0] : 99, 1);
    drain_and_perf();

    // Randomized traffic with random backpressure and manager delay.
    do_reset();
    rand_en = 1'b1;
    repeat (1500) step();
    drain_and_perf();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
